// File: rtl/mem_bus_pkg.sv
// Shared memory-bus types: bus widths, arbiter states and the packed request
// carried by every master that talks to the SRAM port.
package mem_bus_pkg;

  localparam int unsigned MEM_ADR_W  = 18;
  localparam int unsigned MEM_DATA_W = 16;
  localparam int unsigned MEM_SEL_W  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StResp,
    StErr
  } arb_state_e;

  typedef struct packed {
    logic [MEM_ADR_W-1:0]  adr;
    logic                  write;
    logic [MEM_SEL_W-1:0]  sel;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side handshake bundles used around mem_arbiter.
interface mem_arb_port_if;
  logic                                 req;
  mem_bus_pkg::mem_req_t                cmd;
  logic                                 ack;
  logic                                 err;
  logic [mem_bus_pkg::MEM_DATA_W-1:0]   rdata;

  modport master (output req, cmd, input ack, err, rdata);
  modport slave  (input req, cmd, output ack, err, rdata);
endinterface

interface mem_arb_mem_if;
  logic                                 req;
  mem_bus_pkg::mem_req_t                cmd;
  logic                                 ack;
  logic [mem_bus_pkg::MEM_DATA_W-1:0]   rdata;

  modport master (output req, cmd, input ack, rdata);
  modport slave  (input req, cmd, output ack, rdata);
endinterface

// File: rtl/mem_arb_timeout.sv
// Watchdog counter for one downstream transaction; expired flags the last
// permitted cycle without an acknowledge.
module mem_arb_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  // Counter holds the number of unacked cycles already elapsed.
  assign o_expired = (r_cnt == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SRAM port between core (p0) and debug (p1),
// one transaction in flight, with a watchdog that turns hangs into err pulses.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  mem_arb_port_if.slave  p0,
  mem_arb_port_if.slave  p1,
  mem_arb_mem_if.master  m,
  output logic           o_busy,
  output logic           o_owner
);

  arb_state_e            r_state, w_state_d;
  logic                  r_owner, w_owner_d;
  logic                  r_m_req, w_m_req_d;
  mem_req_t              r_m_cmd, w_m_cmd_d;
  logic [MEM_DATA_W-1:0] r_rdata0, w_rdata0_d;
  logic [MEM_DATA_W-1:0] r_rdata1, w_rdata1_d;
  logic                  w_any, w_winner, w_expired, w_cnt_clr, w_cnt_en;

  assign w_any    = p0.req | p1.req;
  assign w_winner = (p0.req & p1.req) ? ~r_owner : p1.req;

  mem_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_d  = r_state;
    w_owner_d  = r_owner;
    w_m_req_d  = r_m_req;
    w_m_cmd_d  = r_m_cmd;
    w_rdata0_d = r_rdata0;
    w_rdata1_d = r_rdata1;
    w_cnt_clr  = 1'b0;
    w_cnt_en   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_clr = 1'b1;
        if (w_any) begin
          w_state_d = StGrant;
          w_owner_d = w_winner;
          w_m_req_d = 1'b1;
          w_m_cmd_d = w_winner ? p1.cmd : p0.cmd;
        end
      end
      StGrant: begin
        // An ack in the expiry cycle still completes normally.
        if (m.ack) begin
          w_m_req_d = 1'b0;
          w_state_d = StResp;
          if (!r_m_cmd.write) begin
            if (r_owner) w_rdata1_d = m.rdata;
            else         w_rdata0_d = m.rdata;
          end
        end else begin
          w_cnt_en = 1'b1;
          if (w_expired) begin
            w_m_req_d = 1'b0;
            w_state_d = StErr;
          end
        end
      end
      StResp, StErr: w_state_d = StIdle;
      default:       w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_owner  <= 1'b0;
      r_m_req  <= 1'b0;
      r_m_cmd  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state  <= w_state_d;
      r_owner  <= w_owner_d;
      r_m_req  <= w_m_req_d;
      r_m_cmd  <= w_m_cmd_d;
      r_rdata0 <= w_rdata0_d;
      r_rdata1 <= w_rdata1_d;
    end
  end

  assign p0.ack   = (r_state == StResp) & ~r_owner;
  assign p1.ack   = (r_state == StResp) &  r_owner;
  assign p0.err   = (r_state == StErr)  & ~r_owner;
  assign p1.err   = (r_state == StErr)  &  r_owner;
  assign p0.rdata = r_rdata0;
  assign p1.rdata = r_rdata1;
  assign m.req    = r_m_req;
  assign m.cmd    = r_m_cmd;
  assign o_busy   = (r_state != StIdle);
  assign o_owner  = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requesters and a memory responder feed a
// scoreboard built from the arbitration and watchdog rules.
module tb_mem_arbiter;
  import mem_bus_pkg::*;

  localparam int unsigned TIMEOUT = 4;

  typedef struct {
    int          port;
    bit          err;
    logic [15:0] rdata;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  logic busy, owner;

  mem_arb_port_if p0_if ();
  mem_arb_port_if p1_if ();
  mem_arb_mem_if  m_if ();

  mem_arbiter #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .p0      (p0_if),
    .p1      (p1_if),
    .m       (m_if),
    .o_busy  (busy),
    .o_owner (owner)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat_mode = 0;

  exp_t        sb_q[$];
  int          grant_log[$];
  int          idle_log[$];
  logic [15:0] hold[2];
  int          gcount, last_glen, idle_run;
  bit          prev_mreq, prev_busy, expect_rise, last_w;
  bit [1:0]    prev_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic mem_req_t rand_cmd();
    mem_req_t c;
    c.adr   = 18'($urandom);
    c.write = 1'($urandom);
    c.sel   = 2'($urandom);
    c.wdata = 16'($urandom);
    return c;
  endfunction

  // Memory responder: acks on the lat-th cycle of m_req (lat 0 = never).
  initial begin : responder
    int r_lat, r_cnt;
    bit r_in;
    r_in = 0; r_cnt = 0; r_lat = 0;
    m_if.ack = 1'b0;
    m_if.rdata = '0;
    forever begin
      @(posedge clk); #1;
      m_if.ack   = 1'b0;
      m_if.rdata = 16'($urandom);
      if (!m_if.req || !rst_n) begin
        r_in = 0;
      end else begin
        if (!r_in) begin
          r_in = 1;
          r_cnt = 0;
          case (lat_mode)
            0: r_lat = int'($urandom_range(1, 3));
            1: r_lat = 0;
            2: r_lat = int'(TIMEOUT);
            3: r_lat = int'($urandom_range(0, 5));
            default: r_lat = 1;
          endcase
        end
        r_cnt++;
        if (r_cnt == r_lat) begin
          m_if.ack = 1'b1;
          if (lat_mode == 4) m_if.rdata = 16'hA55A;
        end
      end
    end
  end

  // Monitor: predicts grants and responses, checks them against the DUT.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      gcount = 0; idle_run = 0;
      prev_mreq = 0; prev_busy = 0; expect_rise = 0; last_w = 0;
      prev_req = 2'b00;
      hold[0] = '0; hold[1] = '0;
    end else begin
      if (expect_rise) chk("req_to_mreq", 64'(m_if.req), 64'd1);
      if (p0_if.ack | p0_if.err | p1_if.ack | p1_if.err) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 64'(sb_q.size()), 64'd1);
        end else begin
          exp_t e;
          bit rp;
          e  = sb_q.pop_front();
          rp = p1_if.ack | p1_if.err;
          chk("resp_excl", 64'((p0_if.ack | p0_if.err) & (p1_if.ack | p1_if.err)), 64'd0);
          chk("resp_port", 64'(rp), 64'(e.port));
          chk("resp_kind_err", 64'(rp ? p1_if.err : p0_if.err), 64'(e.err));
          chk("resp_kind_ack", 64'(rp ? p1_if.ack : p0_if.ack), 64'(!e.err));
          chk("resp_time", 64'(cyc), 64'(e.due));
          chk("resp_rdata", 64'(rp ? p1_if.rdata : p0_if.rdata), 64'(e.rdata));
        end
      end
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        chk("missed_resp", 64'(cyc), 64'(sb_q[0].due));
        void'(sb_q.pop_front());
      end
      if (m_if.req && !prev_mreq) begin
        bit w;
        mem_req_t pc;
        w  = (prev_req == 2'b11) ? !last_w : prev_req[1];
        pc = w ? p1_if.cmd : p0_if.cmd;
        chk("grant_had_req", 64'(prev_req[w]), 64'd1);
        chk("owner", 64'(owner), 64'(w));
        chk("busy_gap", 64'(prev_busy), 64'd0);
        chk("busy_grant", 64'(busy), 64'd1);
        chk("m_adr", 64'(m_if.cmd.adr), 64'(pc.adr));
        chk("m_write", 64'(m_if.cmd.write), 64'(pc.write));
        chk("m_sel", 64'(m_if.cmd.sel), 64'(pc.sel));
        chk("m_wdata", 64'(m_if.cmd.wdata), 64'(pc.wdata));
        last_w = w;
        grant_log.push_back(int'(w));
        idle_log.push_back(idle_run);
        gcount = 0;
      end
      if (m_if.req) begin
        gcount++;
        if (m_if.ack) begin
          exp_t e;
          if (!m_if.cmd.write) hold[last_w] = m_if.rdata;
          e.port = int'(last_w); e.err = 0; e.rdata = hold[last_w]; e.due = cyc + 1;
          sb_q.push_back(e);
        end else if (gcount == int'(TIMEOUT)) begin
          exp_t e;
          e.port = int'(last_w); e.err = 1; e.rdata = hold[last_w]; e.due = cyc + 1;
          sb_q.push_back(e);
        end
        if (gcount > int'(TIMEOUT)) chk("mreq_too_long", 64'(gcount), 64'(TIMEOUT));
      end
      if (!m_if.req && prev_mreq) last_glen = gcount;
      idle_run    = busy ? 0 : idle_run + 1;
      expect_rise = !busy && (p0_if.req || p1_if.req);
      prev_mreq   = m_if.req;
      prev_busy   = busy;
      prev_req    = {p1_if.req, p0_if.req};
    end
  end

  task automatic do_txn(input int p, input mem_req_t c, output bit got_err);
    int n;
    @(posedge clk); #1;
    if (p == 0) begin p0_if.req = 1'b1; p0_if.cmd = c; end
    else        begin p1_if.req = 1'b1; p1_if.cmd = c; end
    got_err = 0;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (p == 0 && (p0_if.ack || p0_if.err)) begin got_err = p0_if.err; break; end
      if (p == 1 && (p1_if.ack || p1_if.err)) begin got_err = p1_if.err; break; end
      if (n > 200) begin
        n_cmp++; n_err++;
        $display("FAIL txn_hang: port %0d got no response, required one within 200 cycles", p);
        break;
      end
    end
    @(posedge clk); #1;
    if (p == 0) p0_if.req = 1'b0;
    else        p1_if.req = 1'b0;
  endtask

  initial begin : main
    bit e0, e1, e;
    mem_req_t c;
    rst_n = 1'b0;
    p0_if.req = 1'b0; p0_if.cmd = '0;
    p1_if.req = 1'b0; p1_if.cmd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_mreq", 64'(m_if.req), 64'd0);
    chk("rst_mcmd", 64'(m_if.cmd), 64'd0);
    chk("rst_resp", 64'({p0_if.ack, p0_if.err, p1_if.ack, p1_if.err}), 64'd0);
    chk("rst_rdata", 64'({p0_if.rdata, p1_if.rdata}), 64'd0);
    rst_n = 1'b1;

    // Simultaneous requests: tie goes to p1 first, then alternation.
    lat_mode = 0;
    fork
      begin do_txn(0, rand_cmd(), e0); end
      begin do_txn(1, rand_cmd(), e1); do_txn(1, rand_cmd(), e1); end
    join
    chk("rr_grant_count", 64'(grant_log.size()), 64'd3);
    if (grant_log.size() >= 3) begin
      chk("rr_first", 64'(grant_log[0]), 64'd1);
      chk("rr_second", 64'(grant_log[1]), 64'd0);
      chk("rr_third", 64'(grant_log[2]), 64'd1);
      chk("rr_idle1", 64'(idle_log[1]), 64'd1);
      chk("rr_idle2", 64'(idle_log[2]), 64'd1);
    end

    // Single read with fixed memory data.
    lat_mode = 4;
    c.adr = 18'h00010; c.write = 1'b0; c.sel = 2'b11; c.wdata = 16'h0000;
    do_txn(0, c, e);
    chk("single_err", 64'(e), 64'd0);
    chk("single_rdata", 64'(p0_if.rdata), 64'hA55A);

    // Write pass-through leaves p1 rdata alone.
    lat_mode = 0;
    c.adr = 18'h3FFFF; c.write = 1'b1; c.sel = 2'b10; c.wdata = 16'h7F00;
    do_txn(1, c, e);
    chk("write_err", 64'(e), 64'd0);
    chk("write_rdata_kept", 64'(p1_if.rdata), 64'(hold[1]));

    // Memory never answers: err after TIMEOUT cycles of m_req.
    lat_mode = 1;
    do_txn(0, rand_cmd(), e);
    chk("timeout_err", 64'(e), 64'd1);
    chk("timeout_mreq_len", 64'(last_glen), 64'(TIMEOUT));
    lat_mode = 0;
    do_txn(0, rand_cmd(), e);
    chk("after_timeout_ok", 64'(e), 64'd0);

    // Ack in the last permitted cycle wins over the watchdog.
    lat_mode = 2;
    do_txn(0, rand_cmd(), e);
    chk("collision_ack", 64'(e), 64'd0);
    chk("collision_len", 64'(last_glen), 64'(TIMEOUT));

    // Random traffic from both ports, random latencies including hangs.
    lat_mode = 3;
    fork
      begin
        repeat (15) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          do_txn(0, rand_cmd(), e0);
        end
      end
      begin
        repeat (15) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          do_txn(1, rand_cmd(), e1);
        end
      end
    join
    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset in the middle of a p1 grant.
    lat_mode = 1;
    @(posedge clk); #1;
    p1_if.req = 1'b1; p1_if.cmd = rand_cmd();
    begin : wait_grant
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (m_if.req) disable wait_grant;
      end
    end
    chk("midrst_granted", 64'(m_if.req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mreq", 64'(m_if.req), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_owner", 64'(owner), 64'd0);
    chk("midrst_resp", 64'({p0_if.ack, p0_if.err, p1_if.ack, p1_if.err}), 64'd0);
    p1_if.req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_owner", 64'(owner), 64'd0);
    lat_mode = 0;
    do_txn(1, rand_cmd(), e);
    chk("post_rst_txn", 64'(e), 64'd0);
    repeat (3) @(posedge clk);
    chk("sb_final", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
